down_timer: RTL and testbench
=============================

# down_timer

Loadable 8-bit down-counting timer built from T flip-flops. It is the count-down counterpart of the team's T-flip-flop up counter, used as a rate divider and interval timer in the lab datapath. It takes a start value, decrements once per qualified `Tick`, and flags expiry with a one-cycle `Done` pulse. It supports one-shot and auto-reload modes. `Done` drives downstream counter enables and display logic.

## Interface
Parameters:
- `WIDTH`, default 8: counter width in bits.

Ports:
- `Clock`, input, 1: single clock; all state changes on the rising edge.
- `Resetn`, input, 1: reset, asynchronous and active-low.
- `Clear`, input, 1: synchronous abort; returns the block to idle.
- `Start`, input, 1: load `LoadValue` and begin counting.
- `Reload`, input, 1: mode select, sampled only at an accepted `Start`. 1 = auto-reload, 0 = one-shot.
- `LoadValue`, input, WIDTH: start/period value, sampled at an accepted `Start`.
- `Tick`, input, 1: count enable; one decrement per cycle in which it is high.
- `CounterValue`, output, WIDTH: current count (Q outputs of the T flip-flops).
- `Busy`, output, 1: high while in RUN.
- `Done`, output, 1: registered one-cycle expiry pulse.

## Operation
- States: IDLE, RUN.
- Registers:
  - `CounterValue`
  - `period` (WIDTH)
  - `mode` (1 bit)
  - `Done` (1 bit)
  - state
- Per-edge priority, highest first: `Resetn` low, then `Clear`, then `Start`, then `Tick`.
- Reset (async): state IDLE; `CounterValue`=0, `period`=0, `mode`=0, `Done`=0, `Busy`=0.
- Clear: state IDLE, `CounterValue`=0, `Done`=0. `period` and `mode` are kept.
- Start, accepted in any state (restart allowed mid-count):
  - Latch `period`←`LoadValue` and `mode`←`Reload`, and set `CounterValue`←`LoadValue`.
  - If `LoadValue`≠0: state RUN.
  - If `LoadValue`=0: state IDLE and `Done`=1 next cycle, regardless of `Reload`. Zero is always one-shot.
- RUN, `Tick`=1, `CounterValue`>1: `CounterValue`←`CounterValue`−1.
- RUN, `Tick`=1, `CounterValue`=1 (expiry):
  - `Done`←1.
  - If `mode`=1: `CounterValue`←`period`, stay in RUN.
  - If `mode`=0: `CounterValue`←0, state IDLE.
- RUN, `Tick`=0: hold.
- IDLE: `Tick` is ignored; `CounterValue` holds.
- `Done` is cleared on every edge where no expiry or zero-start occurs. It is never high for two consecutive cycles.
- Decrement logic:
  - Bit i toggles when all lower bits are 0 (bit 0 always toggles).
  - Parallel load is done through the toggle inputs: T = Q ^ D.
  - No wrap-around below 0 is possible, because expiry is taken at 1.

## Timing
- Start-to-first-decrement: `Start` at edge n, earliest decrement at edge n+1 with `Tick` high. A `Tick` coincident with an accepted `Start` is ignored.
- Period: with `LoadValue`=N≥1 and `Tick` continuously high, `Done` is high during the cycle after edge n+N.
- In auto-reload with continuous `Tick`, `Done` pulses every N cycles.
- `Busy` is the registered state decode. It rises the cycle after `Start` and falls the cycle after a one-shot expiry, the same cycle `Done` is high.
- Start coincident with expiry: `Start` wins and no `Done` is generated.
- `Clear` coincident with expiry: no `Done`.
- `Resetn` asserted mid-count: outputs go to reset values immediately, without waiting for `Clock`. Counting resumes only after deassertion and a new `Start`.

## Structure
- Shared package `timer_pkg`:
  - `state_t` enum {IDLE, RUN}
  - `TIMER_WIDTH` = 8 constant
- Sub-module `t_flipflop_arn`: T flip-flop with async active-low reset and enable. Instantiated WIDTH times via generate.
- Top level holds the FSM, the `period`/`mode`/`Done` registers, and the toggle-enable logic.

## Test plan
- Reset mid-count: `Start` with `LoadValue`=5, 2 ticks, then `Resetn` low between edges → `CounterValue`=0, `Busy`=0, `Done`=0 immediately.
- One-shot: `LoadValue`=3, `Reload`=0, continuous `Tick` → `CounterValue` 3,2,1,0; `Done` high exactly one cycle; `Busy` falls the same cycle; further ticks leave 0.
- Auto-reload: `LoadValue`=4, `Reload`=1, 12 ticks → `Done` pulses every 4 cycles (3 pulses); `CounterValue` sequence 4,3,2,1,4,…
- Full width and sparse ticks: `LoadValue`=8'hFF, `Tick` every other cycle → `Done` after 255 ticks (510 cycles); borrow chain correct at 8'h80→8'h7F and 8'h10→8'h0F.
- Zero load: `LoadValue`=0, `Reload`=1 → `Done` one cycle, `Busy` never high, `CounterValue`=0.
- Collisions:
  - `Start` (`LoadValue`=9) on the expiry edge → `CounterValue`=9, no `Done`.
  - `Clear` with `Tick` → `CounterValue`=0, `Busy`=0.
  - `Start` with `Tick` → load only, no decrement.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the down-counting timer.
package timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int TIMER_WIDTH = 8;

endpackage

// File: rtl/t_flipflop_arn.sv
// T flip-flop with asynchronous active-low reset and a toggle enable.
module t_flipflop_arn (
    input  logic Clock,
    input  logic Resetn,
    input  logic Enable,
    input  logic T,
    output logic Q
);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            Q <= 1'b0;
        end else if (Enable && T) begin
            Q <= ~Q;
        end
    end

endmodule

// File: rtl/down_timer.sv
// Loadable down-counting timer built from T flip-flops, with one-shot and
// auto-reload modes and a registered one-cycle Done pulse on expiry.
module down_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Clear,
    input  logic             Start,
    input  logic             Reload,
    input  logic [WIDTH-1:0] LoadValue,
    input  logic             Tick,
    output logic [WIDTH-1:0] CounterValue,
    output logic             Busy,
    output logic             Done
);

    state_t           state;
    logic [WIDTH-1:0] period;
    logic             mode;
    logic [WIDTH-1:0] borrow;
    logic [WIDTH-1:0] toggle;
    logic             count_en;
    logic             at_one;
    logic             tff_en;

    assign count_en = (state == RUN) && Tick;
    assign at_one   = (CounterValue == WIDTH'(1));
    assign tff_en   = Clear || Start || count_en;

    // Bit i flips on a decrement only when every lower bit is zero.
    assign borrow[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_borrow
        assign borrow[i] = (CounterValue[i-1:0] == '0);
    end

    // Loads go through the toggle inputs: flipping Q ^ D turns Q into D.
    always_comb begin
        toggle = '0;
        if (Clear) begin
            toggle = CounterValue;
        end else if (Start) begin
            toggle = CounterValue ^ LoadValue;
        end else if (count_en) begin
            if (!at_one) begin
                toggle = borrow;
            end else if (mode) begin
                toggle = CounterValue ^ period;
            end else begin
                toggle = CounterValue;
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_tff
        t_flipflop_arn u_tff (
            .Clock  (Clock),
            .Resetn (Resetn),
            .Enable (tff_en),
            .T      (toggle[i]),
            .Q      (CounterValue[i])
        );
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state  <= IDLE;
            Busy   <= 1'b0;
            period <= '0;
            mode   <= 1'b0;
            Done   <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (Clear) begin
                state <= IDLE;
                Busy  <= 1'b0;
            end else if (Start) begin
                period <= LoadValue;
                mode   <= Reload;
                if (LoadValue != '0) begin
                    state <= RUN;
                    Busy  <= 1'b1;
                end else begin
                    // A zero load expires at once and never reloads.
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b1;
                end
            end else if (count_en && at_one) begin
                Done <= 1'b1;
                if (!mode) begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: vector table, corner sequences, random run.
module tb_down_timer;
    import timer_pkg::*;

    localparam int W = TIMER_WIDTH;

    logic         Clock = 1'b0;
    logic         Resetn;
    logic         Clear;
    logic         Start;
    logic         Reload;
    logic [W-1:0] LoadValue;
    logic         Tick;
    logic [W-1:0] CounterValue;
    logic         Busy;
    logic         Done;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_cnt;
    int m_per;
    bit m_md;
    bit m_run;
    bit m_done;

    typedef struct {
        bit       clr;
        bit       st;
        bit       rl;
        bit       tk;
        bit [7:0] lv;
        int       cnt;
        bit       busy;
        bit       done;
    } vec_t;

    vec_t vecs[$];

    always #5 Clock = ~Clock;

    down_timer #(.WIDTH(W)) dut (
        .Clock        (Clock),
        .Resetn       (Resetn),
        .Clear        (Clear),
        .Start        (Start),
        .Reload       (Reload),
        .LoadValue    (LoadValue),
        .Tick         (Tick),
        .CounterValue (CounterValue),
        .Busy         (Busy),
        .Done         (Done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_per = 0; m_md = 0; m_run = 0; m_done = 0;
    endtask

    // Behaviour at one clock edge, from the rules of the timer.
    task automatic model_edge();
        m_done = 0;
        if (Clear) begin
            m_cnt = 0;
            m_run = 0;
        end else if (Start) begin
            m_per = LoadValue;
            m_md  = Reload;
            m_cnt = LoadValue;
            m_run = (LoadValue != 0);
            m_done = (LoadValue == 0);
        end else if (m_run && Tick) begin
            if (m_cnt == 1) begin
                m_done = 1;
                if (m_md) m_cnt = m_per;
                else begin
                    m_cnt = 0;
                    m_run = 0;
                end
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
    endtask

    task automatic set_in(input bit clr, input bit st, input bit rl, input bit [7:0] lv, input bit tk);
        Clear = clr; Start = st; Reload = rl; LoadValue = lv; Tick = tk;
    endtask

    task automatic step();
        @(posedge Clock);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".cnt"},  CounterValue, m_cnt);
        check({tag, ".busy"}, Busy, m_run);
        check({tag, ".done"}, Done, m_done);
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        set_in(0, 0, 0, 8'd0, 0);
        repeat (2) @(posedge Clock);
        #1;
        Resetn = 1'b1;
        model_reset();
    endtask

    initial begin
        int pulses;
        int done_at;
        bit saw80;
        bit saw10;
        int prev;

        do_reset();
        check("reset.cnt", CounterValue, 0);
        check("reset.busy", Busy, 0);
        check("reset.done", Done, 0);

        // clr st rl tk lv : cnt busy done
        vecs.push_back('{0, 1, 0, 1, 8'd3, 3, 1, 0}); // Tick with Start ignored
        vecs.push_back('{0, 0, 0, 1, 8'd0, 2, 1, 0});
        vecs.push_back('{0, 0, 0, 1, 8'd0, 1, 1, 0});
        vecs.push_back('{0, 0, 0, 1, 8'd0, 0, 0, 1}); // one-shot expiry
        vecs.push_back('{0, 0, 0, 1, 8'd0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 8'd0, 0, 0, 0});
        vecs.push_back('{0, 1, 1, 0, 8'd4, 4, 1, 0});
        vecs.push_back('{0, 0, 0, 1, 8'd0, 3, 1, 0});
        vecs.push_back('{0, 0, 0, 1, 8'd0, 2, 1, 0});
        vecs.push_back('{0, 0, 0, 1, 8'd0, 1, 1, 0});
        vecs.push_back('{0, 0, 0, 1, 8'd0, 4, 1, 1}); // reload
        vecs.push_back('{0, 0, 0, 0, 8'd0, 4, 1, 0}); // hold
        vecs.push_back('{0, 0, 0, 1, 8'd0, 3, 1, 0});
        vecs.push_back('{0, 1, 1, 0, 8'd0, 0, 0, 1}); // zero load
        vecs.push_back('{0, 0, 0, 0, 8'd0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 8'd2, 2, 1, 0});
        vecs.push_back('{0, 0, 0, 1, 8'd0, 1, 1, 0});
        vecs.push_back('{0, 1, 0, 1, 8'd9, 9, 1, 0}); // Start on expiry edge
        vecs.push_back('{1, 0, 0, 1, 8'd0, 0, 0, 0}); // Clear with Tick
        vecs.push_back('{0, 0, 0, 1, 8'd0, 0, 0, 0}); // idle ignores Tick
        vecs.push_back('{0, 1, 0, 0, 8'd1, 1, 1, 0});
        vecs.push_back('{1, 0, 0, 1, 8'd0, 0, 0, 0}); // Clear on expiry edge
        vecs.push_back('{0, 1, 0, 0, 8'h80, 8'h80, 1, 0});
        vecs.push_back('{0, 0, 0, 1, 8'd0, 8'h7F, 1, 0});

        foreach (vecs[i]) begin
            set_in(vecs[i].clr, vecs[i].st, vecs[i].rl, vecs[i].lv, vecs[i].tk);
            step();
            check($sformatf("vec%0d.cnt", i), CounterValue, vecs[i].cnt);
            check($sformatf("vec%0d.busy", i), Busy, vecs[i].busy);
            check($sformatf("vec%0d.done", i), Done, vecs[i].done);
        end

        // Asynchronous reset mid-count
        set_in(0, 1, 0, 8'd5, 0);
        step();
        set_in(0, 0, 0, 8'd0, 1);
        step();
        step();
        check("midcnt.cnt", CounterValue, 3);
        #2;
        Resetn = 1'b0;
        #1;
        model_reset();
        check("async.cnt", CounterValue, 0);
        check("async.busy", Busy, 0);
        check("async.done", Done, 0);
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        step();
        check_model("postreset");

        // Auto-reload, 12 continuous ticks
        set_in(0, 1, 1, 8'd4, 0);
        step();
        check_model("ar.load");
        set_in(0, 0, 0, 8'd0, 1);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            check_model($sformatf("ar%0d", i));
            if (Done === 1'b1) pulses++;
        end
        check("ar.pulses", pulses, 3);

        // Full width with a tick every other cycle
        set_in(0, 1, 0, 8'hFF, 0);
        step();
        check_model("fw.load");
        done_at = -1;
        saw80 = 0;
        saw10 = 0;
        prev = CounterValue;
        for (int i = 1; i <= 520; i++) begin
            Start = 1'b0;
            Tick = (i % 2 == 0);
            step();
            check_model("fw");
            if (prev == 8'h80 && CounterValue == 8'h7F) saw80 = 1;
            if (prev == 8'h10 && CounterValue == 8'h0F) saw10 = 1;
            if (Done === 1'b1 && done_at < 0) done_at = i;
            prev = CounterValue;
        end
        check("fw.done_at", done_at, 510);
        check("fw.borrow80", saw80, 1);
        check("fw.borrow10", saw10, 1);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            bit       rc;
            bit       rs;
            bit       rr;
            bit [7:0] rv;
            rc = ($urandom_range(0, 99) < 3);
            rs = ($urandom_range(0, 99) < 8);
            rv = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
            rr = 1'($urandom);
            if (rv == 8'd1) rr = 1'b0;
            set_in(rc, rs, rr, rv, 1'($urandom_range(0, 99) < 60));
            step();
            check_model("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
